game_round_scorer: RTL and testbench

Parametrised round/score engine for the N-choice one-hot "beats" game, e.g. cat/dog/chicken at N=3.
- Replaces the fixed 9-way scenario decode and the hard-coded first-to-3 compare.
- Sits between the switch/key inputs and the draw controller.
- Latches both players' choices on a choose press, resolves the round, and holds the result until continue. Keeps per-player scores and flags the match winner.

---
 rtl/game_round_scorer_if.sv | 41 ++++
 rtl/game_round_scorer.sv | 107 ++++++++++
 tb/tb_game_round_scorer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/game_round_scorer_if.sv
// game_round_scorer_if: choice/button inputs and score/result outputs of the round scorer (draws present when GAME_DRAW_COUNT_EN is defined)
interface game_round_scorer_if #(
  parameter int NUM_CHOICES = 3,
  parameter int SCORE_W = 4
);
  localparam int IW = $clog2(NUM_CHOICES);
  logic [NUM_CHOICES-1:0] p1_choice;
  logic [NUM_CHOICES-1:0] p2_choice;
  logic choose;
  logic cont;
  logic reset_game;
  logic [SCORE_W-1:0] player1;
  logic [SCORE_W-1:0] player2;
  logic [1:0] round_result;
  logic result_valid;
  logic winner1;
  logic winner2;
  logic [IW-1:0] p1_idx;
  logic [IW-1:0] p2_idx;
  logic busy;
`ifdef GAME_DRAW_COUNT_EN
  logic [SCORE_W-1:0] draws;
  modport master(
    output p1_choice, p2_choice, choose, cont, reset_game,
    input player1, player2, round_result, result_valid, winner1, winner2, p1_idx, p2_idx, busy, draws
  );
  modport slave(
    input p1_choice, p2_choice, choose, cont, reset_game,
    output player1, player2, round_result, result_valid, winner1, winner2, p1_idx, p2_idx, busy, draws
  );
`else
  modport master(
    output p1_choice, p2_choice, choose, cont, reset_game,
    input player1, player2, round_result, result_valid, winner1, winner2, p1_idx, p2_idx, busy
  );
  modport slave(
    input p1_choice, p2_choice, choose, cont, reset_game,
    output player1, player2, round_result, result_valid, winner1, winner2, p1_idx, p2_idx, busy
  );
`endif
endinterface

// File: rtl/game_round_scorer.sv
// game_round_scorer: N-choice one-hot "beats" round resolver with scores and match winner; GAME_DRAW_COUNT_EN adds a saturating draw counter
module game_round_scorer #(
  parameter int NUM_CHOICES = 3,
  parameter int SCORE_W = 4,
  parameter int WIN_SCORE = 3
) (
  input logic clk,
  input logic resetn,
  game_round_scorer_if.slave bus
);
  localparam int IW = $clog2(NUM_CHOICES);
  localparam logic [IW:0] NC = (IW+1)'(NUM_CHOICES);
  localparam logic [IW:0] HALF = (IW+1)'((NUM_CHOICES - 1) / 2);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  typedef enum logic [1:0] {WAIT, RESOLVE, SHOW, DONE} state_t;
  state_t state;
  logic choose_q, cont_q;
  logic choose_rise, cont_rise;
  logic [IW-1:0] p1_idx, p2_idx, d1, d2;
  logic [IW:0] diff;
  logic [1:0] outcome, round_result;
  logic [SCORE_W-1:0] player1, player2, p1_next, p2_next;
  logic winner1, winner2, result_valid;
  // zero or multi-hot choices fall back to index 0
  function automatic logic [IW-1:0] decode(input logic [NUM_CHOICES-1:0] c);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_CHOICES; i++) idx = c[i] ? (idx | IW'(i)) : idx;
    return $onehot(c) ? idx : '0;
  endfunction
  assign choose_rise = bus.choose & ~choose_q;
  assign cont_rise = bus.cont & ~cont_q;
  assign d1 = decode(bus.p1_choice);
  assign d2 = decode(bus.p2_choice);
  // (p1 - p2) mod N without a divider: both indices are below N
  assign diff = (p1_idx >= p2_idx) ? {1'b0, p1_idx} - {1'b0, p2_idx} : {1'b0, p1_idx} + NC - {1'b0, p2_idx};
  assign outcome = (diff == '0) ? 2'b00 : (diff <= HALF) ? 2'b01 : 2'b10;
  assign p1_next = (outcome == 2'b01 && player1 != WIN) ? player1 + 1'b1 : player1;
  assign p2_next = (outcome == 2'b10 && player2 != WIN) ? player2 + 1'b1 : player2;
`ifdef GAME_DRAW_COUNT_EN
  logic [SCORE_W-1:0] draws;
  // draw counter saturates at all ones and clears with the match
  always_ff @(posedge clk)
    if (!resetn || bus.reset_game) draws <= '0;
    else if (state == RESOLVE && outcome == 2'b00 && draws != '1) draws <= draws + 1'b1;
  assign bus.draws = draws;
`endif
  // round FSM: latch choices, resolve one cycle, show until continue, hold after a match win
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= WAIT;
      choose_q <= 1'b0;
      cont_q <= 1'b0;
      player1 <= '0;
      player2 <= '0;
      round_result <= 2'b00;
      result_valid <= 1'b0;
      winner1 <= 1'b0;
      winner2 <= 1'b0;
      p1_idx <= '0;
      p2_idx <= '0;
    end else begin
      choose_q <= bus.choose;
      cont_q <= bus.cont;
      if (bus.reset_game) begin
        state <= WAIT;
        player1 <= '0;
        player2 <= '0;
        round_result <= 2'b00;
        result_valid <= 1'b0;
        winner1 <= 1'b0;
        winner2 <= 1'b0;
      end else begin
        case (state)
          WAIT: if (choose_rise) begin
            p1_idx <= d1;
            p2_idx <= d2;
            state <= RESOLVE;
          end
          RESOLVE: begin
            round_result <= outcome;
            player1 <= p1_next;
            player2 <= p2_next;
            winner1 <= p1_next == WIN;
            winner2 <= p2_next == WIN;
            result_valid <= 1'b1;
            state <= SHOW;
          end
          SHOW: if (cont_rise) begin
            result_valid <= 1'b0;
            state <= (winner1 || winner2) ? DONE : WAIT;
          end
          default: state <= DONE;
        endcase
      end
    end
  end
  assign bus.player1 = player1;
  assign bus.player2 = player2;
  assign bus.round_result = round_result;
  assign bus.result_valid = result_valid;
  assign bus.winner1 = winner1;
  assign bus.winner2 = winner2;
  assign bus.p1_idx = p1_idx;
  assign bus.p2_idx = p2_idx;
  assign bus.busy = state != WAIT;
endmodule

// File: tb/tb_game_round_scorer.sv
// tb_game_round_scorer: randomized scoreboard bench for a 3-choice and a 5-choice scorer
module tb_game_round_scorer;
  typedef struct packed {
    logic [1:0] rr;
    logic [7:0] s1, s2;
    logic w1, w2;
    logic [7:0] i1, i2, dr;
  } exp_t;
  typedef struct packed {
    logic [1:0] rr;
    logic [7:0] s1, s2;
    logic rv, w1, w2;
    logic [7:0] i1, i2;
    logic busy;
    logic [7:0] dr;
  } obs_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  int nch[2] = '{3, 5};
  int win[2] = '{3, 2};
  int s1[2], s2[2], dr[2], li1[2], li2[2], over[2];
  logic prv[2] = '{1'b0, 1'b0};
  exp_t q0[$];
  exp_t q1[$];
  game_round_scorer_if #(.NUM_CHOICES(3), .SCORE_W(4)) b0();
  game_round_scorer_if #(.NUM_CHOICES(5), .SCORE_W(4)) b1();
  game_round_scorer #(.NUM_CHOICES(3), .SCORE_W(4), .WIN_SCORE(3)) dut0(.clk(clk), .resetn(resetn), .bus(b0.slave));
  game_round_scorer #(.NUM_CHOICES(5), .SCORE_W(4), .WIN_SCORE(2)) dut1(.clk(clk), .resetn(resetn), .bus(b1.slave));
  always #5 clk = ~clk;
  function automatic obs_t snap(int k);
    obs_t o;
    o = '0;
    if (k == 0) begin
      o.rr = b0.round_result; o.s1 = 8'(b0.player1); o.s2 = 8'(b0.player2); o.rv = b0.result_valid;
      o.w1 = b0.winner1; o.w2 = b0.winner2; o.i1 = 8'(b0.p1_idx); o.i2 = 8'(b0.p2_idx); o.busy = b0.busy;
`ifdef GAME_DRAW_COUNT_EN
      o.dr = 8'(b0.draws);
`endif
    end else begin
      o.rr = b1.round_result; o.s1 = 8'(b1.player1); o.s2 = 8'(b1.player2); o.rv = b1.result_valid;
      o.w1 = b1.winner1; o.w2 = b1.winner2; o.i1 = 8'(b1.p1_idx); o.i2 = 8'(b1.p2_idx); o.busy = b1.busy;
`ifdef GAME_DRAW_COUNT_EN
      o.dr = 8'(b1.draws);
`endif
    end
    return o;
  endfunction
  task automatic chk(input int k, input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL inst%0d %s got %0d expected %0d at %0t", k, nm, got, want, $time);
    end
  endtask
  task automatic set_choices(input int k, input int c1, input int c2);
    if (k == 0) begin b0.p1_choice = 3'(c1); b0.p2_choice = 3'(c2); end
    else begin b1.p1_choice = 5'(c1); b1.p2_choice = 5'(c2); end
  endtask
  task automatic set_btn(input int k, input logic ch, input logic co, input logic rg);
    if (k == 0) begin b0.choose = ch; b0.cont = co; b0.reset_game = rg; end
    else begin b1.choose = ch; b1.cont = co; b1.reset_game = rg; end
  endtask
  function automatic int dec(int k, int c);
    int m;
    m = c & ((1 << nch[k]) - 1);
    if ($countones(m) != 1) return 0;
    for (int i = 0; i < nch[k]; i++) if (((m >> i) & 1) == 1) return i;
    return 0;
  endfunction
  function automatic int gen(int k);
    if ($urandom_range(0, 3) != 0) return 1 << $urandom_range(0, nch[k] - 1);
    return int'($urandom_range(0, (1 << nch[k]) - 1));
  endfunction
  function automatic void clear_match(int k);
    s1[k] = 0; s2[k] = 0; dr[k] = 0; over[k] = 0;
  endfunction
  // reference: decide the round from the rule, update scores, queue the expected display
  task automatic expect_round(input int k, input int c1, input int c2);
    exp_t e;
    int a, b, d, n;
    n = nch[k]; a = dec(k, c1); b = dec(k, c2);
    d = ((a - b) % n + n) % n;
    e.rr = (d == 0) ? 2'd0 : (d <= (n - 1) / 2) ? 2'd1 : 2'd2;
    if (e.rr == 2'd1 && s1[k] < win[k]) s1[k]++;
    if (e.rr == 2'd2 && s2[k] < win[k]) s2[k]++;
    if (e.rr == 2'd0 && dr[k] < 15) dr[k]++;
    li1[k] = a; li2[k] = b;
    e.s1 = 8'(s1[k]); e.s2 = 8'(s2[k]); e.w1 = s1[k] == win[k]; e.w2 = s2[k] == win[k];
    e.i1 = 8'(a); e.i2 = 8'(b); e.dr = 8'(dr[k]);
    over[k] = int'(e.w1 | e.w2);
    if (k == 0) q0.push_back(e); else q1.push_back(e);
  endtask
  task automatic wait_rv(input int k);
    obs_t o;
    int n;
    n = 0;
    o = snap(k);
    while (!o.rv && n < 20) begin @(negedge clk); o = snap(k); n++; end
    if (!o.rv) chk(k, "result_valid_timeout", 0, 1);
  endtask
  task automatic press_cont(input int k, input logic ch);
    obs_t o;
    set_btn(k, ch, 1'b1, 1'b0); @(negedge clk); set_btn(k, ch, 1'b0, 1'b0);
    o = snap(k);
    chk(k, "after_cont_valid", int'(o.rv), 0);
    chk(k, "after_cont_busy", int'(o.busy), over[k]);
  endtask
  task automatic play(input int k, input int c1, input int c2, input int hold);
    expect_round(k, c1, c2);
    set_choices(k, c1, c2); set_btn(k, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    set_choices(k, int'($urandom), int'($urandom));
    repeat (hold - 1) @(negedge clk);
    set_btn(k, 1'b0, 1'b0, 1'b0);
    wait_rv(k);
    press_cont(k, 1'b0);
  endtask
  task automatic held(input int k, input int c1, input int c2);
    obs_t o;
    expect_round(k, c1, c2);
    set_choices(k, c1, c2); set_btn(k, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    wait_rv(k);
    press_cont(k, 1'b1);
    repeat (5) @(negedge clk);
    o = snap(k);
    chk(k, "held_choose_busy", int'(o.busy), over[k]);
    set_btn(k, 1'b0, 1'b0, 1'b0); @(negedge clk);
  endtask
  task automatic cont_idle(input int k);
    obs_t o;
    set_btn(k, 1'b0, 1'b1, 1'b0); @(negedge clk); set_btn(k, 1'b0, 1'b0, 1'b0); @(negedge clk);
    o = snap(k);
    chk(k, "idle_cont_busy", int'(o.busy), 0);
    chk(k, "idle_cont_valid", int'(o.rv), 0);
  endtask
  task automatic done_probe(input int k);
    obs_t o;
    set_choices(k, gen(k), gen(k)); set_btn(k, 1'b1, 1'b0, 1'b0); @(negedge clk);
    set_btn(k, 1'b0, 1'b0, 1'b0); repeat (3) @(negedge clk);
    o = snap(k);
    chk(k, "done_busy", int'(o.busy), 1);
    chk(k, "done_valid", int'(o.rv), 0);
    chk(k, "done_p1", int'(o.s1), s1[k]);
    chk(k, "done_p2", int'(o.s2), s2[k]);
    chk(k, "done_w1", int'(o.w1), int'(s1[k] == win[k]));
    chk(k, "done_w2", int'(o.w2), int'(s2[k] == win[k]));
  endtask
  task automatic check_cleared(input int k, input string nm);
    obs_t o;
    o = snap(k);
    chk(k, {nm, "_p1"}, int'(o.s1), 0);
    chk(k, {nm, "_p2"}, int'(o.s2), 0);
    chk(k, {nm, "_w"}, int'({o.w1, o.w2}), 0);
    chk(k, {nm, "_rr"}, int'(o.rr), 0);
    chk(k, {nm, "_valid"}, int'(o.rv), 0);
    chk(k, {nm, "_busy"}, int'(o.busy), 0);
    chk(k, {nm, "_p1_idx"}, int'(o.i1), li1[k]);
    chk(k, {nm, "_p2_idx"}, int'(o.i2), li2[k]);
`ifdef GAME_DRAW_COUNT_EN
    chk(k, {nm, "_draws"}, int'(o.dr), 0);
`endif
  endtask
  task automatic new_match(input int k, input logic with_choose);
    obs_t o;
    set_choices(k, gen(k), gen(k)); set_btn(k, with_choose, 1'b0, 1'b1); @(negedge clk);
    set_btn(k, 1'b0, 1'b0, 1'b0);
    clear_match(k);
    check_cleared(k, "reset_game");
    @(negedge clk);
    o = snap(k);
    chk(k, "reset_game_priority_busy", int'(o.busy), 0);
  endtask
  task automatic do_reset();
    resetn = 1'b0;
    for (int k = 0; k < 2; k++) begin set_btn(k, 1'b0, 1'b0, 1'b0); set_choices(k, 0, 0); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 2; k++) begin clear_match(k); li1[k] = 0; li2[k] = 0; check_cleared(k, "reset"); end
  endtask
  // monitor: each new displayed result is matched against the oldest expected round
  always @(negedge clk) begin
    obs_t o;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      o = snap(k);
      if (o.rv && !prv[k]) begin
        if ((k == 0 ? q0.size() : q1.size()) == 0) chk(k, "unexpected_result", 1, 0);
        else begin
          if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk(k, "round_result", int'(o.rr), int'(e.rr));
          chk(k, "player1", int'(o.s1), int'(e.s1));
          chk(k, "player2", int'(o.s2), int'(e.s2));
          chk(k, "winner1", int'(o.w1), int'(e.w1));
          chk(k, "winner2", int'(o.w2), int'(e.w2));
          chk(k, "p1_idx", int'(o.i1), int'(e.i1));
          chk(k, "p2_idx", int'(o.i2), int'(e.i2));
`ifdef GAME_DRAW_COUNT_EN
          chk(k, "draws", int'(o.dr), int'(e.dr));
`endif
        end
      end
      prv[k] = o.rv;
    end
  end
  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin set_btn(i, 1'b0, 1'b0, 1'b0); set_choices(i, 0, 0); end
    @(negedge clk);
    do_reset();
    play(0, 'b010, 'b001, 1);
    play(0, 'b011, 'b001, 2);
    held(0, 'b100, 'b100);
    cont_idle(0);
    repeat (3) play(0, 'b001, 'b010, 1);
    done_probe(0);
    new_match(0, 1'b1);
    play(1, 'b00100, 'b00001, 1);
    play(1, 'b01000, 'b00001, 1);
    play(1, 'b00100, 'b00001, 3);
    done_probe(1);
    new_match(1, 1'b0);
    for (int it = 0; it < 120; it++) begin
      k = int'($urandom_range(0, 1));
      if (it == 60) do_reset();
      else if (over[k] != 0) begin done_probe(k); new_match(k, 1'($urandom_range(0, 1))); end
      else case ($urandom_range(0, 11))
        0: new_match(k, 1'($urandom_range(0, 1)));
        1: cont_idle(k);
        2: held(k, gen(k), gen(k));
        default: play(k, gen(k), gen(k), int'($urandom_range(1, 3)));
      endcase
    end
    repeat (3) @(negedge clk);
    chk(0, "pending_rounds", q0.size(), 0);
    chk(1, "pending_rounds", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
